// File: rtl/resp_checker.sv
// resp_checker: on-chip response analyzer for the gate z = a & ~b.
// Predicts each accepted vector, aligns the prediction with dut_z through a LAT-deep line, and tallies results.
module resp_checker #(
  parameter int LAT   = 1,
  parameter int NVEC  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stim_valid,
  input  logic             stim_a,
  input  logic             stim_b,
  input  logic             dut_z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_seen,
  output logic [1:0]       fail_vec,
  output logic             all_pass
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] NVEC_C  = CNT_W'(NVEC);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             fail_seen_q, fail_seen_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       accept;
  logic       clear_line;
  logic       line_empty;
  logic       cmp_valid;
  logic       cmp_match;
  logic [3:0] push_entry;
  logic [3:0] cmp_entry;

  // Line entry layout: {valid, a, b, expected}
  assign accept     = (state_q == RUN) && stim_valid && (issued_q < NVEC_C);
  assign clear_line = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign push_entry = {accept, stim_a, stim_b, stim_a & ~stim_b};
  assign cmp_valid  = cmp_entry[3];
  assign cmp_match  = (dut_z == cmp_entry[0]);

  if (LAT == 0) begin : g_nolat
    assign cmp_entry  = push_entry;
    assign line_empty = 1'b1;
  end else begin : g_lat
    logic [3:0] dl_q [LAT];
    logic [3:0] dl_d [LAT];

    always_comb begin
      dl_d[0] = push_entry;
      for (int i = 1; i < LAT; i++) dl_d[i] = dl_q[i-1];
      if (clear_line) begin
        for (int i = 0; i < LAT; i++) dl_d[i] = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < LAT; i++) dl_q[i] <= '0;
      end else begin
        dl_q <= dl_d;
      end
    end

    always_comb begin
      line_empty = 1'b1;
      for (int i = 0; i < LAT; i++) begin
        if (dl_q[i][3]) line_empty = 1'b0;
      end
    end

    assign cmp_entry = dl_q[LAT-1];
  end

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_seen_d = fail_seen_q;
    fail_vec_d  = fail_vec_q;

    // Compare runs independently of pushes so a retiring entry never stalls a new accept
    if (cmp_valid) begin
      if (cmp_match) begin
        if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
      end else begin
        if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
        if (!fail_seen_q) fail_vec_d = cmp_entry[2:1];
        fail_seen_d = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          issued_d    = '0;
          pass_d      = '0;
          fail_d      = '0;
          fail_seen_d = 1'b0;
          fail_vec_d  = 2'b00;
        end
      end
      RUN: begin
        if (accept) begin
          issued_d = issued_q + 1'b1;
          if (issued_q == NVEC_C - 1'b1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (line_empty) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      issued_q    <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      fail_seen_q <= 1'b0;
      fail_vec_q  <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_seen_q <= fail_seen_d;
      fail_vec_q  <= fail_vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign fail_seen = fail_seen_q;
  assign fail_vec  = fail_vec_q;
  assign all_pass  = done_q & ~fail_seen_q & (pass_q == NVEC_C);

endmodule

// File: tb/tb_resp_checker.sv
// tb_resp_checker: directed bench driving four resp_checker configurations from one stimulus stream.
// A behavioral gate (correct, a&b, or always-wrong) stands in for the checked DUT.
module tb_resp_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stim_valid = 1'b0;
  logic stim_a = 1'b0;
  logic stim_b = 1'b0;
  int   fmode = 0;
  logic z_now;
  logic [2:0] zpipe = 3'b000;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc;

  logic       busy_l1, done_l1, fs_l1, ap_l1;
  logic [7:0] pass_l1, fail_l1;
  logic [1:0] fv_l1;
  logic       busy_l3, done_l3, fs_l3, ap_l3;
  logic [7:0] pass_l3, fail_l3;
  logic [1:0] fv_l3;
  logic       busy_l0, done_l0, fs_l0, ap_l0;
  logic [7:0] pass_l0, fail_l0;
  logic [1:0] fv_l0;
  logic       busy_s, done_s, fs_s, ap_s;
  logic [1:0] pass_s, fail_s;
  logic [1:0] fv_s;

  always #5 clk = ~clk;

  // fmode 0: correct gate, 1: a&b, 2: inverted correct response
  assign z_now = (fmode == 0) ? (stim_a & ~stim_b) :
                 (fmode == 1) ? (stim_a & stim_b) : ~(stim_a & ~stim_b);

  always @(posedge clk) zpipe <= {zpipe[1:0], z_now};

  resp_checker #(.LAT(1), .NVEC(4), .CNT_W(8)) u_l1 (
    .clk(clk), .reset(reset), .start(start), .stim_valid(stim_valid),
    .stim_a(stim_a), .stim_b(stim_b), .dut_z(zpipe[0]),
    .busy(busy_l1), .done(done_l1), .pass_cnt(pass_l1), .fail_cnt(fail_l1),
    .fail_seen(fs_l1), .fail_vec(fv_l1), .all_pass(ap_l1));

  resp_checker #(.LAT(3), .NVEC(4), .CNT_W(8)) u_l3 (
    .clk(clk), .reset(reset), .start(start), .stim_valid(stim_valid),
    .stim_a(stim_a), .stim_b(stim_b), .dut_z(zpipe[2]),
    .busy(busy_l3), .done(done_l3), .pass_cnt(pass_l3), .fail_cnt(fail_l3),
    .fail_seen(fs_l3), .fail_vec(fv_l3), .all_pass(ap_l3));

  resp_checker #(.LAT(0), .NVEC(4), .CNT_W(8)) u_l0 (
    .clk(clk), .reset(reset), .start(start), .stim_valid(stim_valid),
    .stim_a(stim_a), .stim_b(stim_b), .dut_z(z_now),
    .busy(busy_l0), .done(done_l0), .pass_cnt(pass_l0), .fail_cnt(fail_l0),
    .fail_seen(fs_l0), .fail_vec(fv_l0), .all_pass(ap_l0));

  resp_checker #(.LAT(1), .NVEC(3), .CNT_W(2)) u_s (
    .clk(clk), .reset(reset), .start(start), .stim_valid(stim_valid),
    .stim_a(stim_a), .stim_b(stim_b), .dut_z(zpipe[0]),
    .busy(busy_s), .done(done_s), .pass_cnt(pass_s), .fail_cnt(fail_s),
    .fail_seen(fs_s), .fail_vec(fv_s), .all_pass(ap_s));

  // Inputs change on the falling edge; on return the outputs of the current cycle are visible
  task automatic applyStimulus(input logic st, input logic v, input logic a, input logic b);
    @(negedge clk);
    start      = st;
    stim_valid = v;
    stim_a     = a;
    stim_b     = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // Start pulse, then the four exhaustive vectors back-to-back in cycles 0..3
  task automatic runExhaustive();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, i[1], i[0]);
  endtask

  function automatic logic doneOf(input int which);
    case (which)
      0:       return done_l1;
      1:       return done_l3;
      2:       return done_l0;
      default: return done_s;
    endcase
  endfunction

  // Idles until the chosen instance reports done; cur is the cycle index now being observed
  task automatic waitDone(input int which, input int cur, output int at);
    at = cur;
    while (!doneOf(which) && at < cur + 40) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      at++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] gap_v;
    logic [1:0] gap_ab [8];

    // Reset state
    doReset();
    checkOutput("rst_busy", busy_l1, 0);
    checkOutput("rst_done", done_l1, 0);
    checkOutput("rst_pass", pass_l1, 0);
    checkOutput("rst_fail", fail_l1, 0);
    checkOutput("rst_fail_seen", fs_l1, 0);
    checkOutput("rst_fail_vec", fv_l1, 0);
    checkOutput("rst_all_pass", ap_l1, 0);

    // Exhaustive vectors, correct DUT, LAT=1
    fmode = 0;
    runExhaustive();
    checkOutput("ok_busy_c3", busy_l1, 1);
    waitDone(0, 3, cyc);
    checkOutput("ok_done_cycle", cyc, 6);
    checkOutput("ok_pass", pass_l1, 4);
    checkOutput("ok_fail", fail_l1, 0);
    checkOutput("ok_fail_seen", fs_l1, 0);
    checkOutput("ok_all_pass", ap_l1, 1);
    checkOutput("ok_busy_done", busy_l1, 0);

    // Faulty DUT computing a&b
    doReset();
    fmode = 1;
    runExhaustive();
    waitDone(0, 3, cyc);
    checkOutput("bad_done_cycle", cyc, 6);
    checkOutput("bad_pass", pass_l1, 2);
    checkOutput("bad_fail", fail_l1, 2);
    checkOutput("bad_fail_seen", fs_l1, 1);
    checkOutput("bad_fail_vec", fv_l1, 2'b10);
    checkOutput("bad_all_pass", ap_l1, 0);

    // Gapped stimulus, LAT=3; the final pulse arrives after issued reached 4
    doReset();
    fmode = 0;
    gap_v = 8'b1101_1001;
    gap_ab[0] = 2'b00; gap_ab[1] = 2'b00; gap_ab[2] = 2'b00; gap_ab[3] = 2'b01;
    gap_ab[4] = 2'b10; gap_ab[5] = 2'b00; gap_ab[6] = 2'b11; gap_ab[7] = 2'b10;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, gap_v[k], gap_ab[k][1], gap_ab[k][0]);
      checkOutput($sformatf("gap_busy_c%0d", k), busy_l3, 1);
    end
    waitDone(1, 7, cyc);
    checkOutput("gap_done_cycle", cyc, 11);
    checkOutput("gap_pass", pass_l3, 4);
    checkOutput("gap_fail", fail_l3, 0);
    checkOutput("gap_all_pass", ap_l3, 1);

    // Reset mid-run after two accepts, then a fresh full run
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_pass_before", pass_l1, 1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("mid_busy", busy_l1, 0);
    checkOutput("mid_done", done_l1, 0);
    checkOutput("mid_pass", pass_l1, 0);
    checkOutput("mid_fail", fail_l1, 0);
    checkOutput("mid_fail_seen", fs_l1, 0);
    checkOutput("mid_all_pass", ap_l1, 0);
    runExhaustive();
    waitDone(0, 3, cyc);
    checkOutput("mid_rerun_pass", pass_l1, 4);
    checkOutput("mid_rerun_all_pass", ap_l1, 1);

    // Saturation with an always-failing DUT, start pulsed while busy
    doReset();
    fmode = 2;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("sat_busy_c1", busy_s, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("sat_fail_c2", fail_s, 1);
    waitDone(3, 2, cyc);
    checkOutput("sat_done_cycle", cyc, 5);
    checkOutput("sat_fail", fail_s, 3);
    checkOutput("sat_pass", pass_s, 0);
    checkOutput("sat_fail_seen", fs_s, 1);
    checkOutput("sat_fail_vec", fv_s, 2'b11);
    checkOutput("sat_all_pass", ap_s, 0);

    // Start in DONE clears results; second run on a correct DUT
    fmode = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("sat2_fail_clr", fail_s, 0);
    checkOutput("sat2_fs_clr", fs_s, 0);
    checkOutput("sat2_done_clr", done_s, 0);
    checkOutput("sat2_busy", busy_s, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    waitDone(3, 2, cyc);
    checkOutput("sat2_pass", pass_s, 3);
    checkOutput("sat2_fail", fail_s, 0);
    checkOutput("sat2_all_pass", ap_s, 1);

    // LAT=0: each compare lands at its own accept edge, DRAIN lasts one cycle
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, i[1], i[0]);
      checkOutput($sformatf("l0_pass_c%0d", i), pass_l0, i);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("l0_pass_c4", pass_l0, 4);
    checkOutput("l0_busy_c4", busy_l0, 1);
    checkOutput("l0_done_c4", done_l0, 0);
    waitDone(2, 4, cyc);
    checkOutput("l0_done_cycle", cyc, 5);
    checkOutput("l0_all_pass", ap_l0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/resp_checker.md
Name: resp_checker

Overview:
- Synthesizable self-checking response analyzer for the 2-input gate datapath z = a & ~b.
- Sits on the DUT side of the stimulus interface. It accepts stimulus vectors (a, b) as they are applied and computes the expected value. It delays that value to line up with the DUT response, compares, and accumulates pass/fail statistics.
- The same exhaustive check therefore runs on-chip, with results readable as registers.

Parameters:
- LAT, 1, cycles between stimulus acceptance and the valid DUT response on dut_z; legal range 0..8.
- NVEC, 4, number of vectors per run; legal range 1..2**CNT_W-1.
- CNT_W, 8, width of the pass/fail/issued counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a run; honoured in IDLE or DONE only.
- stim_valid  input  1  stimulus present this cycle.
- stim_a  input  1  stimulus input a.
- stim_b  input  1  stimulus input b.
- dut_z  input  1  DUT output, valid LAT cycles after the matching accepted stimulus.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.
- pass_cnt  output  CNT_W  compares that matched.
- fail_cnt  output  CNT_W  compares that mismatched.
- fail_seen  output  1  at least one mismatch this run.
- fail_vec  output  2  {a,b} of the first mismatching vector.
- all_pass  output  1  done & ~fail_seen & (pass_cnt == NVEC).

Behaviour:
- Reset: the synchronous reset has priority over all other inputs. It gives state=IDLE, and busy, done, pass_cnt, fail_cnt, fail_seen and fail_vec all 0. The issued counter and every delay-line valid bit are also cleared.
- Reset mid-run: the run is abandoned with no partial results retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE with start=1: clear the counters, fail_seen, fail_vec and the delay line, then go to RUN on the next cycle.
- RUN:
  - Accept = stim_valid while issued < NVEC.
  - On accept: exp = stim_a & ~stim_b. Push {valid=1, a, b, exp} into the delay line and increment issued.
  - Cycles without stim_valid push a bubble (valid=0). Gaps are legal.
- RUN exit: when issued reaches NVEC (on the accepting cycle), go to DRAIN next cycle. stim_valid is ignored in DRAIN and DONE.
- Delay line:
  - LAT stages of registers.
  - Compare point = the stage-LAT output.
  - LAT=0: compare combinationally against the current stim/dut_z in the accepting cycle, with results registered at that edge.
- Compare (when the compare-point valid=1):
  - match (dut_z == exp): pass_cnt += 1.
  - else: fail_cnt += 1. If fail_seen==0, capture fail_vec={a,b}. Set fail_seen=1.
- Counters: saturate at 2**CNT_W-1 and never wrap.
- DRAIN → DONE: on the cycle after the last valid entry has been compared, i.e. when the delay line is empty.
- LAT=0: DRAIN lasts exactly one cycle.
- DONE: results held stable; done stays high until start or reset.
- start while busy: ignored; no counter disturbance.
- Latency: with back-to-back stim_valid from the cycle after start, done rises NVEC+LAT+1 cycles after the first accept edge.
- Compare-point valid and a new accept in the same cycle: both are handled. The push and compare are independent, with no stall.

Test Plan:
- Exhaustive vectors with a correct DUT. LAT=1, NVEC=4; vectors (0,0),(0,1),(1,0),(1,1) back-to-back, dut_z=a&~b delayed 1 cycle. Required: pass_cnt=4, fail_cnt=0, fail_seen=0, all_pass=1, done high 6 cycles after the first accept edge.
- Faulty DUT. Same stimulus, but the DUT computes a&b. Required: fail_cnt=2, pass_cnt=2, fail_seen=1, fail_vec=2'b10, all_pass=0.
- Gapped stimulus. LAT=3; stim_valid pattern 1,0,0,1,1,0,1 with a correct DUT. Required: pass_cnt=4; busy stays high throughout; the stim_valid pulse after issued=4 is ignored; done only after the delay line empties.
- Reset mid-run. Assert reset after 2 accepts. Required: the next cycle shows IDLE with every output 0. Then a fresh start plus the full run gives pass_cnt=4.
- Saturation and start-while-busy.
  - Setup: CNT_W=2, NVEC=3, and a faulty DUT that always fails, with a second run on a correct DUT.
  - Required: fail_cnt=3 with no wrap.
  - Pulse start during RUN: the counters are unaffected.
  - Pulse start in DONE: the counters clear to 0 the next cycle and a second correct run gives pass_cnt=3.
- LAT=0. Correct combinational DUT, NVEC=4. Required: each compare is registered at its accept edge; DRAIN lasts 1 cycle; all_pass=1.
